data_mem_responder: RTL



---
 rtl/data_mem_responder_if.sv | 37 +++
 rtl/data_mem_responder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// Data-port bus between the CPU (master) and the memory responder (slave).
// Optional DATA_MEM_RESPONDER_MISALIGN_CHECK_EN adds err_o to the bus.
interface data_mem_responder_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   // valid/ready: a level request (mem_read_i/mem_write_i) is accepted in the
   // first cycle it is seen while the responder is idle; the CPU stalls while
   // busy_o is high and r_data_o is valid in the first cycle busy_o is low.
   logic                  mem_read_i;
   logic                  mem_write_i;
   logic [ADDR_WIDTH-1:0] addr_i;
   logic [DATA_WIDTH-1:0] w_data_i;
   logic [DATA_WIDTH-1:0] r_data_o;
   logic                  busy_o;
`ifdef DATA_MEM_RESPONDER_MISALIGN_CHECK_EN
   logic                  err_o;

   modport master (
      output mem_read_i, mem_write_i, addr_i, w_data_i,
      input  r_data_o, busy_o, err_o
   );
   modport slave (
      input  mem_read_i, mem_write_i, addr_i, w_data_i,
      output r_data_o, busy_o, err_o
   );
`else
   modport master (
      output mem_read_i, mem_write_i, addr_i, w_data_i,
      input  r_data_o, busy_o
   );
   modport slave (
      input  mem_read_i, mem_write_i, addr_i, w_data_i,
      output r_data_o, busy_o
   );
`endif
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed RAM responder with fixed LATENCY-cycle busy pulse per access.
// Optional misalignment check: define DATA_MEM_RESPONDER_MISALIGN_CHECK_EN.
module data_mem_responder #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   data_mem_responder_if.slave  bus,
   output logic [1:0]           dbg_state
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic [3:0]            cnt, cnt_nxt;
   logic                  busy;
   logic                  req;

   logic [IDX_W-1:0]      lat_idx;
   logic [DATA_WIDTH-1:0] lat_wdata;
   logic                  lat_write;

   logic [IDX_W-1:0]      acc_idx;
   logic [DATA_WIDTH-1:0] acc_wdata;
   logic                  acc_write;
   logic                  finishing;
   logic                  bad_align;
   logic                  ram_we;
   logic                  ram_re;

   logic [DATA_WIDTH-1:0] ram [DEPTH_WORDS];
   logic [DATA_WIDTH-1:0] r_data;

   assign req = bus.mem_read_i | bus.mem_write_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         lat_idx   <= '0;
         lat_wdata <= '0;
         lat_write <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == IDLE && req) begin
            lat_idx   <= bus.addr_i[2 +: IDX_W];
            lat_wdata <= bus.w_data_i;
            lat_write <= bus.mem_write_i;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            busy = req;
            if (req) begin
               if (LATENCY == 1) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            busy = 1'b1;
            if (cnt == 4'd0) state_nxt = DONE;
            else             cnt_nxt   = cnt - 4'd1;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // With LATENCY==1 the access happens on the edge leaving IDLE, so the
   // operands come straight from the bus instead of the latches.
   always_comb begin
      if (state == IDLE) begin
         acc_idx   = bus.addr_i[2 +: IDX_W];
         acc_wdata = bus.w_data_i;
         acc_write = bus.mem_write_i;
      end else begin
         acc_idx   = lat_idx;
         acc_wdata = lat_wdata;
         acc_write = lat_write;
      end
   end

   assign finishing = (state_nxt == DONE);

`ifdef DATA_MEM_RESPONDER_MISALIGN_CHECK_EN
   logic [1:0] lat_lo;
   logic [1:0] acc_lo;
   logic       err;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lat_lo <= 2'd0;
         err    <= 1'b0;
      end else begin
         if (state == IDLE && req) lat_lo <= bus.addr_i[1:0];
         err <= finishing & bad_align;
      end
   end

   assign acc_lo    = (state == IDLE) ? bus.addr_i[1:0] : lat_lo;
   assign bad_align = (acc_lo != 2'd0);
   assign bus.err_o = err;
`else
   assign bad_align = 1'b0;
`endif

   // Reset held across an edge must not let a pending write reach the RAM.
   assign ram_we = finishing & acc_write & ~bad_align & ~rst_i;
   assign ram_re = finishing & ~acc_write;

   always_ff @(posedge clk_i) begin
      if (ram_we) ram[acc_idx] <= acc_wdata;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)       r_data <= '0;
      else if (ram_re) r_data <= ram[acc_idx];
   end

   assign bus.r_data_o = r_data;
   assign bus.busy_o   = busy & ~rst_i;
   assign dbg_state    = state;

   logic unused_addr;
   assign unused_addr = &{1'b0, bus.addr_i};
endmodule
